// File: rtl/alu_pkg.sv
// Shared constants, FSM state encoding and program-word layout for the ALU
// program sequencer and its ALU neighbours.
package alu_pkg;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned OPW        = 5;
    localparam int unsigned DW         = 2;
    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned LENW       = AW + 1;
    localparam int unsigned WORDW      = OPW + 3 * DW + 1;
    localparam int unsigned CNTW       = 3;
    localparam int unsigned FAILW      = 4;
    localparam int unsigned FAIL_MAX   = 15;
    localparam int unsigned SETTLE_DEF = 1;

    // Bit positions inside the 12-bit program word
    localparam int unsigned OP_MSB = 11;
    localparam int unsigned OP_LSB = 7;
    localparam int unsigned A_MSB  = 6;
    localparam int unsigned A_LSB  = 5;
    localparam int unsigned B_MSB  = 4;
    localparam int unsigned B_LSB  = 3;
    localparam int unsigned ER_MSB = 2;
    localparam int unsigned ER_LSB = 1;
    localparam int unsigned ES_BIT = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Field order matches the bit positions above (MSB first)
    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [DW-1:0]  exp_res;
        logic           exp_status;
    } prog_word_t;

endpackage

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x 12 register file, synchronous write, async read.
// Ports: clk, we/waddr/wdata write port, raddr read address,
//        rdata_c combinational read data as a decoded program word.
module alu_prog_mem
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WORDW-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output prog_word_t       rdata_c
);

    prog_word_t mem [DEPTH];

    // Contents survive reset on purpose; only writes change them
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= prog_word_t'(wdata);
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/alu_program_sequencer.sv
// Issue stage for the combinational ALU: steps through a loaded program,
// drives operands, waits SETTLE cycles, compares res/status to expected.
// Ports: clk, rst (sync, active-high); prog_we/prog_addr/prog_data program
//        load; prog_len/start/stop run control; in_A/in_B/opcode to ALU;
//        res/status from ALU; i, busy, done, fail_count, led progress.
module alu_program_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned SETTLE = SETTLE_DEF
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [WORDW-1:0] prog_data,
    input  logic [LENW-1:0]  prog_len,
    input  logic             start,
    input  logic             stop,
    output logic [DW-1:0]    in_A,
    output logic [DW-1:0]    in_B,
    output logic [OPW-1:0]   opcode,
    input  logic [DW-1:0]    res,
    input  logic             status,
    output logic [AW-1:0]    i,
    output logic             busy,
    output logic             done,
    output logic [FAILW-1:0] fail_count,
    output logic             led
);

    state_t            state;
    logic [LENW-1:0]   len;
    logic [CNTW-1:0]   settle_cnt;
    prog_word_t        entry_c;
    logic              mem_we_c;
    logic [LENW-1:0]   len_clamp_c;
    logic              mismatch_c;
    logic              last_c;
    logic [FAILW-1:0]  fail_next_c;

    // Program may only change while no run is in flight
    assign mem_we_c = prog_we && (state == ST_IDLE || state == ST_DONE);

    alu_prog_mem u_mem (
        .clk     (clk),
        .we      (mem_we_c),
        .waddr   (prog_addr),
        .wdata   (prog_data),
        .raddr   (i),
        .rdata_c (entry_c)
    );

    assign len_clamp_c = (prog_len > LENW'(DEPTH)) ? LENW'(DEPTH) : prog_len;
    assign mismatch_c  = (res != entry_c.exp_res) || (status != entry_c.exp_status);
    assign last_c      = ({1'b0, i} == (len - LENW'(1)));
    assign fail_next_c = (mismatch_c && (fail_count != FAILW'(FAIL_MAX)))
                         ? fail_count + FAILW'(1) : fail_count;

    // Run FSM; every output is updated alongside its state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            len        <= '0;
            settle_cnt <= '0;
            in_A       <= '0;
            in_B       <= '0;
            opcode     <= '0;
            i          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            fail_count <= '0;
            led        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // stop wins over start
                    if (start && !stop) begin
                        len        <= len_clamp_c;
                        fail_count <= '0;
                        i          <= '0;
                        if (len_clamp_c == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                            led   <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            led   <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        in_A       <= entry_c.a;
                        in_B       <= entry_c.b;
                        opcode     <= entry_c.op;
                        settle_cnt <= CNTW'(SETTLE);
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (settle_cnt == CNTW'(1)) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNTW'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        fail_count <= fail_next_c;
                        if (last_c) begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            led   <= (fail_next_c == '0);
                        end else begin
                            i     <= i + AW'(1);
                            state <= ST_ISSUE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Scoreboard bench for alu_program_sequencer with a small two-opcode ALU model.
module tb_alu_program_sequencer;
    import alu_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             prog_we;
    logic [AW-1:0]    prog_addr;
    logic [WORDW-1:0] prog_data;
    logic [LENW-1:0]  prog_len;
    logic             start;
    logic             stop;
    logic [DW-1:0]    in_A;
    logic [DW-1:0]    in_B;
    logic [OPW-1:0]   opcode;
    logic [DW-1:0]    res;
    logic             status;
    logic [AW-1:0]    i;
    logic             busy;
    logic             done;
    logic [FAILW-1:0] fail_count;
    logic             led;

    always #5 clk = ~clk;

    alu_program_sequencer #(.SETTLE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_len   (prog_len),
        .start      (start),
        .stop       (stop),
        .in_A       (in_A),
        .in_B       (in_B),
        .opcode     (opcode),
        .res        (res),
        .status     (status),
        .i          (i),
        .busy       (busy),
        .done       (done),
        .fail_count (fail_count),
        .led        (led)
    );

    // ALU model: 00001 = ADD mod 4 (status=carry), 00010 = AND (status=zero)
    logic [2:0] sum;
    always_comb begin
        sum    = {1'b0, in_A} + {1'b0, in_B};
        res    = '0;
        status = 1'b0;
        if (opcode == 5'b00001) begin
            res    = sum[1:0];
            status = sum[2];
        end else if (opcode == 5'b00010) begin
            res    = in_A & in_B;
            status = ((in_A & in_B) == 2'b00);
        end
    end

    typedef struct {
        logic [3:0] fail;
        logic       led;
        logic [2:0] idx;
        logic [1:0] a;
        logic [1:0] b;
        logic [4:0] op;
        int         busy_cyc;
        logic       chk_first;
        logic [1:0] a0;
        logic [1:0] b0;
        logic [4:0] op0;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [11:0] word(input logic [4:0] op, input logic [1:0] a,
                                         input logic [1:0] b, input logic [1:0] er,
                                         input logic es);
        return {op, a, b, er, es};
    endfunction

    function automatic exp_t mk(input logic [3:0] f, input logic l, input logic [2:0] ix,
                                input logic [1:0] a, input logic [1:0] b, input logic [4:0] op,
                                input int bc, input logic cf, input logic [1:0] a0,
                                input logic [1:0] b0, input logic [4:0] op0);
        exp_t e;
        e.fail = f; e.led = l; e.idx = ix; e.a = a; e.b = b; e.op = op;
        e.busy_cyc = bc; e.chk_first = cf; e.a0 = a0; e.b0 = b0; e.op0 = op0;
        return e;
    endfunction

    // Monitor: counts busy cycles, captures first issued operands, checks on done rising
    int         busy_cnt  = 0;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;
    logic [1:0] cap_a, cap_b;
    logic [4:0] cap_op;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            busy_prev = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (busy && !busy_prev) busy_cnt = 0;
            if (busy) busy_cnt++;
            if (busy && busy_cnt == 2) begin
                cap_a  = in_A;
                cap_b  = in_B;
                cap_op = opcode;
            end
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: done rose with no run expected at %0t", $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("fail_count", int'(fail_count), int'(e.fail));
                    check("led",        int'(led),        int'(e.led));
                    check("busy_at_done", int'(busy),     0);
                    check("last_i",     int'(i),          int'(e.idx));
                    check("last_in_A",  int'(in_A),       int'(e.a));
                    check("last_in_B",  int'(in_B),       int'(e.b));
                    check("last_opcode", int'(opcode),    int'(e.op));
                    check("busy_cycles", busy_cnt,        e.busy_cyc);
                    if (e.chk_first) begin
                        check("first_in_A",   int'(cap_a),  int'(e.a0));
                        check("first_in_B",   int'(cap_b),  int'(e.b0));
                        check("first_opcode", int'(cap_op), int'(e.op0));
                    end
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
            done_prev = done;
        end
    end

    task automatic load(input logic [2:0] addr, input logic [11:0] data);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        @(negedge clk);
        prog_we   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: done not seen within %0d cycles", budget);
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [3:0] len, input exp_t e);
        sb.push_back(e);
        prog_len = len;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(100);
    endtask

    // Every entry mismatches: status expectation is the inverse of the real carry
    logic [11:0] mis_prog [8];

    initial begin
        mis_prog[0] = word(5'b00001, 2'd0, 2'd2, 2'd2, 1'b1);
        mis_prog[1] = word(5'b00001, 2'd1, 2'd2, 2'd3, 1'b1);
        mis_prog[2] = word(5'b00001, 2'd2, 2'd2, 2'd0, 1'b0);
        mis_prog[3] = word(5'b00001, 2'd3, 2'd2, 2'd1, 1'b0);
        mis_prog[4] = word(5'b00001, 2'd0, 2'd2, 2'd2, 1'b1);
        mis_prog[5] = word(5'b00001, 2'd1, 2'd2, 2'd3, 1'b1);
        mis_prog[6] = word(5'b00001, 2'd2, 2'd2, 2'd0, 1'b0);
        mis_prog[7] = word(5'b00001, 2'd3, 2'd2, 2'd1, 1'b0);

        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        prog_len = '0; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_in_A", int'(in_A), 0);
        check("rst_in_B", int'(in_B), 0);
        check("rst_opcode", int'(opcode), 0);
        check("rst_i", int'(i), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_fail", int'(fail_count), 0);
        check("rst_led", int'(led), 0);

        // Empty program: straight to DONE, busy never high, led on
        run(4'd0, mk(4'd0, 1'b1, 3'd0, 2'd0, 2'd0, 5'd0, 0, 1'b0, 2'd0, 2'd0, 5'd0));

        // Two matching entries: ADD 1+2=3 c0, AND 3&1=1 z0
        load(3'd0, word(5'b00001, 2'b01, 2'b10, 2'b11, 1'b0));
        load(3'd1, word(5'b00010, 2'b11, 2'b01, 2'b01, 1'b0));
        run(4'd2, mk(4'd0, 1'b1, 3'd1, 2'd3, 2'd1, 5'd2, 6, 1'b1, 2'd1, 2'd2, 5'd1));

        // Same program with a wrong expected result on entry 1
        load(3'd1, word(5'b00010, 2'b11, 2'b01, 2'b10, 1'b0));
        run(4'd2, mk(4'd1, 1'b0, 3'd1, 2'd3, 2'd1, 5'd2, 6, 1'b1, 2'd1, 2'd2, 5'd1));

        // Eight mismatches, rerun without reload, then clamped lengths 9 and 15
        for (int k = 0; k < 8; k++) load(3'(k), mis_prog[k]);
        run(4'd8,  mk(4'd8, 1'b0, 3'd7, 2'd3, 2'd2, 5'd1, 24, 1'b1, 2'd0, 2'd2, 5'd1));
        run(4'd8,  mk(4'd8, 1'b0, 3'd7, 2'd3, 2'd2, 5'd1, 24, 1'b1, 2'd0, 2'd2, 5'd1));
        run(4'd9,  mk(4'd8, 1'b0, 3'd7, 2'd3, 2'd2, 5'd1, 24, 1'b1, 2'd0, 2'd2, 5'd1));
        run(4'd15, mk(4'd8, 1'b0, 3'd7, 2'd3, 2'd2, 5'd1, 24, 1'b1, 2'd0, 2'd2, 5'd1));

        // Abort during SETTLE of entry 1 with a write attempt mid-run
        prog_len = 4'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (i != 3'd1 && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("reach_entry1", int'(i), 1);
        prog_we = 1'b1; prog_addr = 3'd0;
        prog_data = word(5'b00001, 2'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        prog_we = 1'b0;
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_busy", int'(busy), 0);
        check("stop_done", int'(done), 0);
        check("stop_fail_hold", int'(fail_count), 1);
        check("stop_in_A_hold", int'(in_A), 1);
        check("stop_in_B_hold", int'(in_B), 2);
        check("stop_led", int'(led), 0);
        @(negedge clk);
        check("stop_stays_idle", int'(busy), 0);

        // Readback run: a landed write to mem[0] would give 7, not 8
        run(4'd8, mk(4'd8, 1'b0, 3'd7, 2'd3, 2'd2, 5'd1, 24, 1'b1, 2'd0, 2'd2, 5'd1));

        // Reset while in SAMPLE of a mismatching entry
        prog_len = 4'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst_in_A", int'(in_A), 0);
        check("mrst_in_B", int'(in_B), 0);
        check("mrst_opcode", int'(opcode), 0);
        check("mrst_i", int'(i), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_fail", int'(fail_count), 0);
        check("mrst_led", int'(led), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(busy), 0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
